// File: rtl/accel_mem_arbiter_if.sv
// Bus bundle between NUM_REQ accelerator masters, the arbiter and the
// 128-bit accel-to-memory bridge port.
//
// Handshake: a transfer on either side completes in the cycle where the
// strobe (write or read) is high and waitrequest is low; while waitrequest
// is high the master holds its strobe, address and writedata stable.
// Readdata is valid only in that completion cycle.
interface accel_mem_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 128
);
  logic [NUM_REQ*DATA_W-1:0] avs_accel_writedata;
  logic [NUM_REQ-1:0]        avs_accel_address;
  logic [NUM_REQ-1:0]        avs_accel_write;
  logic [NUM_REQ-1:0]        avs_accel_read;
  logic [NUM_REQ*DATA_W-1:0] avs_accel_readdata;
  logic [NUM_REQ-1:0]        avs_accel_waitrequest;
  logic [DATA_W-1:0]         avm_bridge_writedata;
  logic                      avm_bridge_address;
  logic                      avm_bridge_write;
  logic                      avm_bridge_read;
  logic [DATA_W-1:0]         avm_bridge_readdata;
  logic                      avm_bridge_waitrequest;

  // Arbiter view: slave to the accelerators, master to the bridge.
  modport slave (
    input  avs_accel_writedata, avs_accel_address, avs_accel_write, avs_accel_read,
    output avs_accel_readdata, avs_accel_waitrequest,
    output avm_bridge_writedata, avm_bridge_address, avm_bridge_write, avm_bridge_read,
    input  avm_bridge_readdata, avm_bridge_waitrequest
  );

  // Environment view: accelerators plus the bridge.
  modport master (
    output avs_accel_writedata, avs_accel_address, avs_accel_write, avs_accel_read,
    input  avs_accel_readdata, avs_accel_waitrequest,
    input  avm_bridge_writedata, avm_bridge_address, avm_bridge_write, avm_bridge_read,
    output avm_bridge_readdata, avm_bridge_waitrequest
  );
endinterface

// File: rtl/accel_mem_arbiter.sv
// Round-robin arbiter sharing one bridge port between NUM_REQ accelerators.
// One transaction in flight; a mandatory IDLE cycle separates grants.
// A watchdog aborts a BUSY phase lasting TIMEOUT cycles and sets a sticky
// error. grant_valid is the registered FSM state (high = BUSY).
module accel_mem_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 128,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                reset,
  accel_mem_arbiter_if.slave  bus,
  output logic [2:0]          grant_id,
  output logic                grant_valid,
  output logic                timeout_err,
  input  logic                err_clear
);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state;
  logic [2:0]         rr_ptr;
  logic [CNT_W-1:0]   wd_cnt;
  logic [NUM_REQ-1:0] req;
  logic               any_req;
  logic [2:0]         pick;
  logic               g_write, g_read, g_addr;
  logic [DATA_W-1:0]  g_data;
  logic               wd_fire, done, abort;

  assign req = bus.avs_accel_write | bus.avs_accel_read;

  // Round-robin search: first requester after rr_ptr (descending loop so the
  // nearest index is written last and wins).
  always_comb begin
    any_req = 1'b0;
    pick    = rr_ptr;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[(int'(rr_ptr) + k) % NUM_REQ]) begin
        any_req = 1'b1;
        pick    = 3'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  // Select the granted requester's command.
  always_comb begin
    g_write = 1'b0;
    g_read  = 1'b0;
    g_addr  = 1'b0;
    g_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == 3'(i)) begin
        g_write = bus.avs_accel_write[i];
        g_read  = bus.avs_accel_read[i];
        g_addr  = bus.avs_accel_address[i];
        g_data  = bus.avs_accel_writedata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign wd_fire = (TIMEOUT != 0) && (state == BUSY) && (wd_cnt == WD_LAST);
  assign done    = (state == BUSY) && !wd_fire && (g_write | g_read) && !bus.avm_bridge_waitrequest;
  assign abort   = (state == BUSY) && !(g_write | g_read);

  assign bus.avs_accel_readdata = {NUM_REQ{bus.avm_bridge_readdata}};

  // Forward the granted port to the bridge; the watchdog cycle issues nothing.
  always_comb begin
    bus.avm_bridge_writedata  = '0;
    bus.avm_bridge_address    = 1'b0;
    bus.avm_bridge_write      = 1'b0;
    bus.avm_bridge_read       = 1'b0;
    bus.avs_accel_waitrequest = '1;
    if (state == BUSY) begin
      bus.avm_bridge_writedata = g_data;
      bus.avm_bridge_address   = g_addr;
      if (!wd_fire) begin
        bus.avm_bridge_write = g_write;
        bus.avm_bridge_read  = g_read & ~g_write;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (grant_id == 3'(i)) bus.avs_accel_waitrequest[i] = bus.avm_bridge_waitrequest;
        end
      end
    end
  end

  // FSM with registered grant, pointer, watchdog count and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= 3'(NUM_REQ - 1);
      grant_id    <= 3'd0;
      grant_valid <= 1'b0;
      timeout_err <= 1'b0;
      wd_cnt      <= '0;
    end else begin
      // Clear first so a watchdog set in the same cycle overrides it.
      if (err_clear) timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          wd_cnt <= '0;
          if (any_req) begin
            state       <= BUSY;
            grant_valid <= 1'b1;
            grant_id    <= pick;
            rr_ptr      <= pick;
          end
        end
        BUSY: begin
          wd_cnt <= wd_cnt + 1'b1;
          if (wd_fire) begin
            // rr_ptr already points at the offender, so it loses priority.
            timeout_err <= 1'b1;
            state       <= IDLE;
            grant_valid <= 1'b0;
          end else if (done || abort) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          grant_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/accel_mem_arbiter.md
Name: accel_mem_arbiter

Overview:
- Shares one 128-bit accelerator-to-memory bridge port between NUM_REQ accelerator masters.
- Sits between the accelerator instances and the bridge's 128-bit accel slave.
- Arbitration is round-robin with a registered grant. One transaction is in flight at a time.
- A watchdog releases the grant from a stalled transaction and flags a sticky error.

Parameters:
- NUM_REQ, 4, number of requester ports (2..8).
- DATA_W, 128, command/readdata width per port (bit 96..98 size flags, [95:32] data, [30:0] address are passed through untouched).
- TIMEOUT, 1024, max cycles in BUSY before forced release. 0 disables the watchdog.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- avs_accel_writedata  in  NUM_REQ*DATA_W  per-requester command word, slice i = [i*DATA_W +: DATA_W]
- avs_accel_address  in  NUM_REQ  per-requester address bit
- avs_accel_write  in  NUM_REQ  per-requester write strobe
- avs_accel_read  in  NUM_REQ  per-requester read strobe
- avs_accel_readdata  out  NUM_REQ*DATA_W  per-requester readdata, every slice = avm_bridge_readdata (broadcast)
- avs_accel_waitrequest  out  NUM_REQ  per-requester stall
- avm_bridge_writedata  out  DATA_W  command to bridge
- avm_bridge_address  out  1  address bit to bridge
- avm_bridge_write  out  1  write strobe to bridge
- avm_bridge_read  out  1  read strobe to bridge
- avm_bridge_readdata  in  DATA_W  readdata from bridge (valid in completion cycle)
- avm_bridge_waitrequest  in  1  stall from bridge
- grant_id  out  3  index of current/last granted requester
- grant_valid  out  1  high in BUSY
- timeout_err  out  1  sticky watchdog flag
- err_clear  in  1  clears timeout_err

Behaviour:
- Requester i is "requesting" when avs_accel_write[i] | avs_accel_read[i].
- Reset values:
  - state = IDLE, rr_ptr = NUM_REQ-1, grant_id = 0, grant_valid = 0, timeout_err = 0, watchdog count = 0.
  - All avs_accel_waitrequest = 1. avm_bridge_write/read = 0.
  - avm_bridge_writedata/address = 0.
- IDLE:
  - All requester waitrequests high. Bridge strobes low.
  - If any requester is requesting, select the first requesting index searching rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
  - Register the winner into grant_id and rr_ptr, and go to BUSY.
- BUSY (combinational forwarding from the granted port g):
  - avm_bridge_writedata/address = slice g.
  - avm_bridge_write = write[g].
  - avm_bridge_read = read[g] & ~write[g]; write wins if both are asserted.
  - avs_accel_waitrequest[g] = avm_bridge_waitrequest. All other waitrequests = 1.
- Completion:
  - Condition: in BUSY, granted strobe high and avm_bridge_waitrequest = 0.
  - Readdata is valid in that cycle. Next state = IDLE.
- Abort: if the granted requester drops both strobes in BUSY, go to IDLE with no bridge strobe issued that cycle.
- Latency and throughput:
  - Request seen in cycle N. Bridge strobe in N+1. Earliest completion is N+1.
  - One mandatory IDLE cycle between transactions, so peak throughput is 1 access per 2 cycles.
- Non-granted requesters are held (waitrequest high) indefinitely.
- Fairness: the round-robin pointer guarantees any continuously requesting port is granted within NUM_REQ transactions.
- Watchdog:
  - Count increments each BUSY cycle and clears in IDLE.
  - When count reaches TIMEOUT while still BUSY: force bridge strobes low that cycle, set timeout_err = 1, go to IDLE. rr_ptr stays at the offender so it loses priority.
- timeout_err is cleared by err_clear. Set has priority over a simultaneous err_clear.
- Reset mid-transaction: strobes drop to 0 on the next edge. Requester waitrequests return to 1. No completion is reported.
- grant_id holds its last value in IDLE. grant_valid = (state == BUSY).

Test Plan:
- Single requester 1 writes data 0xDEADBEEF to addr 0x10 with bridge waitrequest 0 → bridge write high exactly 1 cycle, 1 cycle after request. avs_accel_waitrequest[1] low in that cycle. grant_id = 1.
- All 4 requesters read continuously from reset → grant order 0,1,2,3,0, each BUSY of 1 cycle separated by 1 IDLE cycle. Each port sees readdata = bridge readdata on its completion cycle.
- Requester 2 reads while bridge waitrequest is held high for 5 cycles → port 2 stalled 5 cycles. Completes on cycle 6 of BUSY. Other pending ports are stalled throughout.
- TIMEOUT = 8, bridge waitrequest stuck high → forced release after 8 BUSY cycles. timeout_err = 1 and stays set until err_clear pulse, then 0. Next grant goes to a different requester if one is pending.
- Requester 0 asserts write and read together → only avm_bridge_write asserted, read = 0.
- Reset asserted during BUSY with bridge waitrequest high → next cycle all strobes 0, all waitrequests 1, grant_valid 0, timeout_err 0.
